// File: rtl/spim_responder.sv
`default_nettype none
// ============================================================================
// Module   : spim_responder
// Brief    : In-fabric SPI mode-0 slave that answers the spim master with a
//            small command set: WRITE (02), READ (03) into an 8-bit register
//            bank, and ID (9F) returning a fixed byte. All SPI inputs are
//            oversampled in the system clock domain; no SCK-clocked logic.
// Revision : 1.0 - initial release
// ============================================================================
module spim_responder #(
    parameter int         MEM_DEPTH   = 16,
    parameter logic [7:0] DEVICE_ID   = 8'hA5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic spi_sck_i,
    input  logic spi_csn_i,
    input  logic spi_mosi_i,
    output logic spi_miso_o,
    output logic spi_miso_oe_o,
    output logic busy_o,
    output logic cmd_err_o
);

    localparam int c_addr_w = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [7:0] c_cmd_write = 8'h02;
    localparam logic [7:0] c_cmd_read  = 8'h03;
    localparam logic [7:0] c_cmd_id    = 8'h9F;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_cmd    = 3'd1;
    localparam logic [2:0] c_st_addr   = 3'd2;
    localparam logic [2:0] c_st_wdata  = 3'd3;
    localparam logic [2:0] c_st_rdata  = 3'd4;
    localparam logic [2:0] c_st_id     = 3'd5;
    localparam logic [2:0] c_st_ignore = 3'd6;

    // Synchroniser chains and previous-sample flops for edge detection
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_csn_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_prev;
    logic                   r_csn_prev;

    // Registered edge events (one cycle after detection)
    logic r_sck_rise;
    logic r_sck_fall;
    logic r_csn_fall;
    logic r_csn_rise;
    logic r_mosi_s;
    logic r_busy;

    // Protocol state
    logic [2:0]          r_state;
    logic [2:0]          r_bit_cnt;
    logic [6:0]          r_shift_in;
    logic [6:0]          r_shift_out;
    logic [c_addr_w-1:0] r_addr;
    logic                r_is_write;
    logic                r_miso;
    logic                r_oe;
    logic                r_cmd_err;
    logic [7:0]          r_mem [MEM_DEPTH];

    logic w_sck_s;
    logic w_csn_s;
    logic [7:0] w_byte;
    logic [7:0] w_entry_rd;
    logic [7:0] w_next_rd;

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_csn_s    = r_csn_sync[SYNC_STAGES-1];
    // Byte completed by the bit sampled on the current rise
    assign w_byte     = {r_shift_in, r_mosi_s};
    // First byte of a READ comes from the address just received
    assign w_entry_rd = r_mem[w_byte[c_addr_w-1:0]];
    assign w_next_rd  = (r_state == c_st_id) ? DEVICE_ID : r_mem[r_addr];

    // Oversample SPI pins and register the edge events they produce
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sck_sync  <= '0;
            r_csn_sync  <= '1;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
            r_csn_prev  <= 1'b1;
            r_sck_rise  <= 1'b0;
            r_sck_fall  <= 1'b0;
            r_csn_fall  <= 1'b0;
            r_csn_rise  <= 1'b0;
            r_mosi_s    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck_i};
            r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], spi_csn_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            r_sck_prev  <= w_sck_s;
            r_csn_prev  <= w_csn_s;
            r_sck_rise  <= w_sck_s & ~r_sck_prev;
            r_sck_fall  <= ~w_sck_s & r_sck_prev;
            r_csn_fall  <= ~w_csn_s & r_csn_prev;
            r_csn_rise  <= w_csn_s & ~r_csn_prev;
            r_mosi_s    <= r_mosi_sync[SYNC_STAGES-1];
            r_busy      <= ~w_csn_s;
        end
    end

    // Frame decoder, register bank and MISO shifter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= c_st_idle;
            r_bit_cnt   <= 3'd0;
            r_shift_in  <= 7'd0;
            r_shift_out <= 7'd0;
            r_addr      <= '0;
            r_is_write  <= 1'b0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
            r_cmd_err   <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            r_cmd_err <= 1'b0;
            if (r_csn_rise) begin
                // End of frame: any partial byte is simply dropped
                r_state    <= c_st_idle;
                r_bit_cnt  <= 3'd0;
                r_shift_in <= 7'd0;
                r_oe       <= 1'b0;
                r_miso     <= 1'b0;
            end else if (r_csn_fall) begin
                r_state    <= c_st_cmd;
                r_bit_cnt  <= 3'd0;
                r_shift_in <= 7'd0;
                r_oe       <= 1'b0;
                r_miso     <= 1'b0;
            end else if (r_sck_rise && (r_state != c_st_idle)) begin
                r_shift_in <= w_byte[6:0];
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    case (r_state)
                        c_st_cmd: begin
                            case (w_byte)
                                c_cmd_write: begin
                                    r_state    <= c_st_addr;
                                    r_is_write <= 1'b1;
                                end
                                c_cmd_read: begin
                                    r_state    <= c_st_addr;
                                    r_is_write <= 1'b0;
                                end
                                c_cmd_id: begin
                                    r_state     <= c_st_id;
                                    r_oe        <= 1'b1;
                                    r_shift_out <= DEVICE_ID[6:0];
                                    r_miso      <= DEVICE_ID[7];
                                end
                                default: begin
                                    r_state   <= c_st_ignore;
                                    r_cmd_err <= 1'b1;
                                end
                            endcase
                        end
                        c_st_addr: begin
                            r_addr <= w_byte[c_addr_w-1:0];
                            if (r_is_write) begin
                                r_state <= c_st_wdata;
                            end else begin
                                // Present the MSB early; the following fall
                                // reloads the same byte and advances addr
                                r_state     <= c_st_rdata;
                                r_oe        <= 1'b1;
                                r_shift_out <= w_entry_rd[6:0];
                                r_miso      <= w_entry_rd[7];
                            end
                        end
                        c_st_wdata: begin
                            r_mem[r_addr] <= w_byte;
                            r_addr        <= r_addr + c_addr_w'(1);
                        end
                        default: begin
                        end
                    endcase
                end
            end else if (r_sck_fall && ((r_state == c_st_rdata) || (r_state == c_st_id))) begin
                if (r_bit_cnt == 3'd0) begin
                    // Byte boundary: load the next byte to send
                    r_shift_out <= w_next_rd[6:0];
                    r_miso      <= w_next_rd[7];
                    if (r_state == c_st_rdata) begin
                        r_addr <= r_addr + c_addr_w'(1);
                    end
                end else begin
                    r_miso      <= r_shift_out[6];
                    r_shift_out <= {r_shift_out[5:0], 1'b0};
                end
            end
        end
    end

    assign spi_miso_o    = r_miso;
    assign spi_miso_oe_o = r_oe;
    assign busy_o        = r_busy;
    assign cmd_err_o     = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_spim_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spim_responder
// Brief    : Directed self-checking bench for spim_responder acting as a
//            mode-0 SPI master with SCK half period of 8 system clocks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spim_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sck   = 1'b0;
    logic csn   = 1'b1;
    logic mosi  = 1'b0;
    wire  miso;
    wire  oe;
    wire  busy;
    wire  cmd_err;

    int n_checks   = 0;
    int n_fail     = 0;
    int err_cycles = 0;

    spim_responder #(
        .MEM_DEPTH  (16),
        .DEVICE_ID  (8'hA5),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .spi_sck_i    (sck),
        .spi_csn_i    (csn),
        .spi_mosi_i   (mosi),
        .spi_miso_o   (miso),
        .spi_miso_oe_o(oe),
        .busy_o       (busy),
        .cmd_err_o    (cmd_err)
    );

    always #5 clk = ~clk;

    // Count every cycle in which the error pulse is high
    always @(posedge clk) begin
        if (cmd_err === 1'b1) err_cycles <= err_cycles + 1;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_begin();
        csn = 1'b0;
        wait_n(8);
    endtask

    task automatic frame_end();
        wait_n(8);
        csn = 1'b1;
        wait_n(12);
    endtask

    // Shift nbits of tx MSB first; capture MISO and OE at each SCK rise
    task automatic xfer(input logic [7:0] tx, input int nbits,
                        output logic [7:0] rx, output logic [7:0] oe_bits);
        rx      = 8'h00;
        oe_bits = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_n(8);
            sck = 1'b1;
            rx[7-i]      = miso;
            oe_bits[7-i] = oe;
            wait_n(8);
            sck = 1'b0;
        end
    endtask

    task automatic read_one(input logic [7:0] addr, output logic [7:0] data);
        logic [7:0] rx, ob;
        frame_begin();
        xfer(8'h03, 8, rx, ob);
        xfer(addr, 8, rx, ob);
        xfer(8'h00, 8, data, ob);
        frame_end();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_n(3);
        n_checks++; if (miso !== 1'b0)    begin n_fail++; $display("FAIL reset_miso got %b exp 0", miso); end
        n_checks++; if (oe !== 1'b0)      begin n_fail++; $display("FAIL reset_oe got %b exp 0", oe); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_err got %b exp 0", cmd_err); end
        rst_n = 1'b1;
        wait_n(6);
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_busy();
        csn = 1'b0;
        wait_n(2);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_early got %b exp 0", busy); end
        wait_n(1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_rise got %b exp 1", busy); end
        csn = 1'b1;
        wait_n(4);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_fall got %b exp 0", busy); end
        wait_n(8);
    endtask

    task automatic test_write_read();
        logic [7:0] rx, ob;
        logic [7:0] exp_d [3];
        exp_d = '{8'h11, 8'h22, 8'h33};
        frame_begin();
        xfer(8'h02, 8, rx, ob);
        xfer(8'h04, 8, rx, ob);
        for (int i = 0; i < 3; i++) xfer(exp_d[i], 8, rx, ob);
        frame_end();
        frame_begin();
        xfer(8'h03, 8, rx, ob);
        n_checks++; if (ob !== 8'h00) begin n_fail++; $display("FAIL rd_oe_cmd got %h exp 00", ob); end
        xfer(8'h04, 8, rx, ob);
        n_checks++; if (ob !== 8'h00) begin n_fail++; $display("FAIL rd_oe_addr got %h exp 00", ob); end
        for (int i = 0; i < 3; i++) begin
            xfer(8'h00, 8, rx, ob);
            n_checks++; if (rx !== exp_d[i]) begin n_fail++; $display("FAIL rd_data%0d got %h exp %h", i, rx, exp_d[i]); end
            n_checks++; if (ob !== 8'hFF)    begin n_fail++; $display("FAIL rd_oe_data%0d got %h exp ff", i, ob); end
        end
        frame_end();
        n_checks++; if (oe !== 1'b0) begin n_fail++; $display("FAIL rd_oe_after got %b exp 0", oe); end
    endtask

    task automatic test_wrap();
        logic [7:0] rx, ob;
        frame_begin();
        xfer(8'h02, 8, rx, ob);
        xfer(8'h0F, 8, rx, ob);
        xfer(8'hAA, 8, rx, ob);
        xfer(8'hBB, 8, rx, ob);
        frame_end();
        frame_begin();
        xfer(8'h03, 8, rx, ob);
        xfer(8'h0F, 8, rx, ob);
        xfer(8'h00, 8, rx, ob);
        n_checks++; if (rx !== 8'hAA) begin n_fail++; $display("FAIL wrap_rd0 got %h exp aa", rx); end
        xfer(8'h00, 8, rx, ob);
        n_checks++; if (rx !== 8'hBB) begin n_fail++; $display("FAIL wrap_rd1 got %h exp bb", rx); end
        frame_end();
        read_one(8'h00, rx);
        n_checks++; if (rx !== 8'hBB) begin n_fail++; $display("FAIL wrap_mem0 got %h exp bb", rx); end
    endtask

    task automatic test_id();
        logic [7:0] rx, ob;
        int e0;
        e0 = err_cycles;
        frame_begin();
        xfer(8'h9F, 8, rx, ob);
        n_checks++; if (ob !== 8'h00) begin n_fail++; $display("FAIL id_oe_cmd got %h exp 00", ob); end
        for (int i = 0; i < 3; i++) begin
            xfer(8'h00, 8, rx, ob);
            n_checks++; if (rx !== 8'hA5) begin n_fail++; $display("FAIL id_byte%0d got %h exp a5", i, rx); end
            n_checks++; if (ob !== 8'hFF) begin n_fail++; $display("FAIL id_oe%0d got %h exp ff", i, ob); end
        end
        frame_end();
        n_checks++; if (err_cycles - e0 != 0) begin n_fail++; $display("FAIL id_cmd_err got %0d exp 0", err_cycles - e0); end
    endtask

    task automatic test_bad_cmd();
        logic [7:0] rx, ob, ob_all;
        int e0;
        e0 = err_cycles;
        ob_all = 8'h00;
        frame_begin();
        xfer(8'h5A, 8, rx, ob);
        ob_all |= ob;
        for (int i = 0; i < 3; i++) begin
            xfer(8'hFF, 8, rx, ob);
            ob_all |= ob;
        end
        frame_end();
        n_checks++; if (err_cycles - e0 != 1) begin n_fail++; $display("FAIL bad_err_pulse got %0d exp 1", err_cycles - e0); end
        n_checks++; if (ob_all !== 8'h00) begin n_fail++; $display("FAIL bad_oe got %h exp 00", ob_all); end
        read_one(8'h04, rx);
        n_checks++; if (rx !== 8'h11) begin n_fail++; $display("FAIL bad_mem4 got %h exp 11", rx); end
        read_one(8'h06, rx);
        n_checks++; if (rx !== 8'h33) begin n_fail++; $display("FAIL bad_mem6 got %h exp 33", rx); end
    endtask

    task automatic test_abort();
        logic [7:0] rx, ob;
        frame_begin();
        xfer(8'h02, 8, rx, ob);
        xfer(8'h02, 8, rx, ob);
        xfer(8'hFF, 5, rx, ob);
        frame_end();
        read_one(8'h02, rx);
        n_checks++; if (rx !== 8'h00) begin n_fail++; $display("FAIL abort_mem2 got %h exp 00", rx); end
        read_one(8'h05, rx);
        n_checks++; if (rx !== 8'h22) begin n_fail++; $display("FAIL abort_next got %h exp 22", rx); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx, ob;
        frame_begin();
        xfer(8'h03, 8, rx, ob);
        xfer(8'h04, 8, rx, ob);
        xfer(8'h00, 3, rx, ob);
        n_checks++; if (oe !== 1'b1) begin n_fail++; $display("FAIL mid_oe_before got %b exp 1", oe); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL mid_rst_miso got %b exp 0", miso); end
        n_checks++; if (oe !== 1'b0)   begin n_fail++; $display("FAIL mid_rst_oe got %b exp 0", oe); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
        csn  = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        wait_n(4);
        rst_n = 1'b1;
        wait_n(10);
        read_one(8'h04, rx);
        n_checks++; if (rx !== 8'h00) begin n_fail++; $display("FAIL mid_mem4 got %h exp 00", rx); end
        read_one(8'h0F, rx);
        n_checks++; if (rx !== 8'h00) begin n_fail++; $display("FAIL mid_mem15 got %h exp 00", rx); end
    endtask

    initial begin
        test_reset();
        test_busy();
        test_write_read();
        test_wrap();
        test_id();
        test_bad_cmd();
        test_abort();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
